nrz_receiver: RTL and testbench

NRZ_RECEIVER -- requirements
Module: nrz_receiver

---
 rtl/nrz_pkg.sv | 13 +
 rtl/sync_2ff.sv | 24 ++
 rtl/nrz_receiver.sv | 168 ++++++++++++++++
 tb/tb_nrz_receiver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/nrz_pkg.sv
// rtl/nrz_pkg.sv - shared NRZ line timing constants for receiver and sequence generator
package nrz_pkg;

    localparam int NRZ_DURATION_CLK_COUNTS      = 62;
    localparam int NRZ_CODE0_HIGH_CLK_COUNTS    = 20;
    localparam int NRZ_CODE1_HIGH_CLK_COUNTS    = 40;
    localparam int NRZ_BIT_THRESHOLD_CLK_COUNTS = 29;
    localparam int NRZ_MIN_HIGH_CLK_COUNTS      = 8;
    localparam int NRZ_MAX_HIGH_CLK_COUNTS      = 50;
    localparam int NRZ_RESET_LOW_CLK_COUNTS     = 2500;
    localparam int NRZ_WORD_BITS                = 24;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/nrz_receiver.sv
// rtl/nrz_receiver.sv - NRZ pulse-width decoder assembling MSB-first words and detecting the latch code
import nrz_pkg::*;

module nrz_receiver #(
    parameter int DURATION_CLK_COUNTS      = NRZ_DURATION_CLK_COUNTS,
    parameter int BIT_THRESHOLD_CLK_COUNTS = NRZ_BIT_THRESHOLD_CLK_COUNTS,
    parameter int MIN_HIGH_CLK_COUNTS      = NRZ_MIN_HIGH_CLK_COUNTS,
    parameter int MAX_HIGH_CLK_COUNTS      = NRZ_MAX_HIGH_CLK_COUNTS,
    parameter int RESET_LOW_CLK_COUNTS     = NRZ_RESET_LOW_CLK_COUNTS,
    parameter int WORD_BITS                = NRZ_WORD_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 din,
    output logic [WORD_BITS-1:0] word_data,
    output logic                 word_valid,
    output logic                 latch,
    output logic                 bit_error,
    output logic                 busy
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HIGH     = 2'd1;
    localparam logic [1:0] ST_LOW      = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW = 2'd3;

    localparam int HIGH_CNT_SAT = MAX_HIGH_CLK_COUNTS + 1;
    localparam int HIGH_W       = $clog2(HIGH_CNT_SAT + 1);
    localparam int LOW_W        = $clog2(RESET_LOW_CLK_COUNTS + 1);
    localparam int BIT_W        = $clog2(WORD_BITS);

    localparam logic [HIGH_W-1:0] HIGH_MIN    = HIGH_W'(MIN_HIGH_CLK_COUNTS);
    localparam logic [HIGH_W-1:0] HIGH_MAX    = HIGH_W'(MAX_HIGH_CLK_COUNTS);
    localparam logic [HIGH_W-1:0] HIGH_SAT    = HIGH_W'(HIGH_CNT_SAT);
    localparam logic [HIGH_W-1:0] HIGH_THRESH = HIGH_W'(BIT_THRESHOLD_CLK_COUNTS);
    localparam logic [LOW_W-1:0]  LOW_LAST    = LOW_W'(RESET_LOW_CLK_COUNTS - 1);
    localparam logic [LOW_W-1:0]  LOW_SAT     = LOW_W'(RESET_LOW_CLK_COUNTS);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(WORD_BITS - 1);

    // Thresholds must be ordered inside one bit period or decoding is meaningless.
    if (!(MIN_HIGH_CLK_COUNTS > 0 &&
          MIN_HIGH_CLK_COUNTS <= BIT_THRESHOLD_CLK_COUNTS &&
          BIT_THRESHOLD_CLK_COUNTS < MAX_HIGH_CLK_COUNTS &&
          MAX_HIGH_CLK_COUNTS < DURATION_CLK_COUNTS &&
          WORD_BITS >= 2)) begin : g_bad_params
        $error("nrz_receiver: inconsistent timing parameters");
    end

    logic                 w_s;
    logic                 w_rise;
    logic                 w_bit;
    logic [WORD_BITS-1:0] w_shift_next;

    logic                 r_s_d;
    logic [1:0]           r_state;
    logic [HIGH_W-1:0]    r_high_cnt;
    logic [LOW_W-1:0]     r_low_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [WORD_BITS-1:0] r_shift;
    logic [WORD_BITS-1:0] r_word_data;
    logic                 r_word_valid;
    logic                 r_latch;
    logic                 r_bit_error;
    logic                 r_pending;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (din),
        .o_q   (w_s)
    );

    assign w_rise       = w_s & ~r_s_d;
    assign w_bit        = (r_high_cnt > HIGH_THRESH);
    assign w_shift_next = {r_shift[WORD_BITS-2:0], w_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_d        <= 1'b0;
            r_state      <= ST_IDLE;
            r_high_cnt   <= '0;
            r_low_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_latch      <= 1'b0;
            r_bit_error  <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_s_d        <= w_s;
            r_word_valid <= 1'b0;
            r_latch      <= 1'b0;
            r_bit_error  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_state    <= ST_HIGH;
                        r_high_cnt <= HIGH_W'(1);
                    end
                end

                ST_HIGH: begin
                    if (w_s) begin
                        if (r_high_cnt == HIGH_MAX) begin
                            r_high_cnt  <= HIGH_SAT;
                            r_bit_error <= 1'b1;
                            r_bit_cnt   <= '0;
                            r_state     <= ST_WAIT_LOW;
                        end else begin
                            r_high_cnt <= r_high_cnt + HIGH_W'(1);
                        end
                    end else begin
                        // Staying in HIGH implies s_d=1, so s=0 here is the falling edge.
                        r_state   <= ST_LOW;
                        r_low_cnt <= LOW_W'(1);
                        if (r_high_cnt < HIGH_MIN) begin
                            r_bit_error <= 1'b1;
                            r_bit_cnt   <= '0;
                        end else begin
                            r_shift   <= w_shift_next;
                            r_pending <= 1'b1;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_bit_cnt    <= '0;
                                r_word_data  <= w_shift_next;
                                r_word_valid <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            end
                        end
                    end
                end

                ST_WAIT_LOW: begin
                    if (!w_s) begin
                        r_state   <= ST_LOW;
                        r_low_cnt <= LOW_W'(1);
                    end
                end

                default: begin
                    if (w_rise) begin
                        r_state    <= ST_HIGH;
                        r_high_cnt <= HIGH_W'(1);
                        r_low_cnt  <= '0;
                    end else if (r_low_cnt == LOW_LAST) begin
                        // Latch code: drop any partial word; only announce if data arrived.
                        r_low_cnt <= LOW_SAT;
                        r_latch   <= r_pending;
                        r_pending <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_low_cnt <= r_low_cnt + LOW_W'(1);
                    end
                end
            endcase
        end
    end

    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign latch      = r_latch;
    assign bit_error  = r_bit_error;
    assign busy       = (r_bit_cnt != '0);

endmodule

// File: tb/tb_nrz_receiver.sv
// tb/tb_nrz_receiver.sv - directed table-driven bench for nrz_receiver
import nrz_pkg::*;

module tb_nrz_receiver;

    localparam int PERIOD = 63;
    localparam int CODE0  = NRZ_CODE0_HIGH_CLK_COUNTS;
    localparam int CODE1  = NRZ_CODE1_HIGH_CLK_COUNTS;

    typedef struct {
        logic [23:0] data;
        logic [23:0] exp_word;
    } word_vec_t;

    typedef struct {
        int   high;
        logic exp_err;
        logic exp_bit;
    } pulse_vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din = 1'b0;
    logic [23:0] word_data;
    logic        word_valid;
    logic        latch;
    logic        bit_error;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_latch = 0;
    int n_err = 0;
    int n_overlap = 0;
    logic [23:0] last_word = '0;

    nrz_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .word_data  (word_data),
        .word_valid (word_valid),
        .latch      (latch),
        .bit_error  (bit_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_valid) begin
            n_valid++;
            last_word = word_data;
        end
        if (latch) n_latch++;
        if (bit_error) n_err++;
        if (latch && word_valid) n_overlap++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse(input int high, input int low);
        din = 1'b1;
        repeat (high) @(negedge clk);
        din = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) pulse(CODE1, PERIOD - CODE1);
        else   pulse(CODE0, PERIOD - CODE0);
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        din   = 1'b0;
        @(negedge clk);
        check("rst_word_data", int'(word_data), 0);
        check("rst_word_valid", int'(word_valid), 0);
        check("rst_latch", int'(latch), 0);
        check("rst_bit_error", int'(bit_error), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    word_vec_t  words[6];
    pulse_vec_t pulses[7];

    initial begin
        int v0, l0, e0;

        words[0] = '{24'h00FF00, 24'h00FF00};
        words[1] = '{24'hA5A5A5, 24'hA5A5A5};
        words[2] = '{24'h123456, 24'h123456};
        words[3] = '{24'hFFFFFF, 24'hFFFFFF};
        words[4] = '{24'h000000, 24'h000000};
        words[5] = '{24'h800001, 24'h800001};

        pulses[0] = '{7,  1'b1, 1'b0};
        pulses[1] = '{8,  1'b0, 1'b0};
        pulses[2] = '{29, 1'b0, 1'b0};
        pulses[3] = '{30, 1'b0, 1'b1};
        pulses[4] = '{50, 1'b0, 1'b1};
        pulses[5] = '{51, 1'b1, 1'b0};
        pulses[6] = '{3,  1'b1, 1'b0};

        do_reset();

        l0 = n_latch;
        repeat (5000) @(negedge clk);
        check("no_latch_after_reset", n_latch - l0, 0);

        foreach (words[i]) begin
            v0 = n_valid; e0 = n_err;
            send_bits(words[i].data, 24);
            check($sformatf("word%0d_valid_cnt", i), n_valid - v0, 1);
            check($sformatf("word%0d_data", i), int'(last_word), int'(words[i].exp_word));
            check($sformatf("word%0d_port", i), int'(word_data), int'(words[i].exp_word));
            check($sformatf("word%0d_err", i), n_err - e0, 0);
        end

        l0 = n_latch;
        repeat (2600) @(negedge clk);
        check("latch_once", n_latch - l0, 1);
        check("latch_busy", int'(busy), 0);
        l0 = n_latch;
        repeat (5000) @(negedge clk);
        check("latch_no_second", n_latch - l0, 0);

        foreach (pulses[i]) begin
            v0 = n_valid; e0 = n_err;
            pulse(pulses[i].high, 60);
            check($sformatf("pulse%0d_err", i), n_err - e0, int'(pulses[i].exp_err));
            if (pulses[i].exp_err) begin
                check($sformatf("pulse%0d_busy", i), int'(busy), 0);
            end else begin
                send_bits(24'h2AAAAA, 23);
                check($sformatf("pulse%0d_valid", i), n_valid - v0, 1);
                check($sformatf("pulse%0d_word", i), int'(last_word),
                      int'({pulses[i].exp_bit, 23'h2AAAAA}));
            end
        end

        // Glitch after 10 good bits aborts the word; previous word_data is held.
        v0 = n_valid; e0 = n_err;
        send_bits(24'h0003FF, 10);
        check("glitch_busy_before", int'(busy), 1);
        pulse(3, 60);
        check("glitch_err", n_err - e0, 1);
        check("glitch_busy_after", int'(busy), 0);
        check("glitch_hold_word", int'(word_data), int'({1'b1, 23'h2AAAAA}));
        send_bits(24'hA5A5A5, 24);
        check("glitch_recover_valid", n_valid - v0, 1);
        check("glitch_recover_word", int'(last_word), 24'hA5A5A5);

        v0 = n_valid; e0 = n_err;
        pulse(60, 60);
        check("long_high_err_once", n_err - e0, 1);
        send_bits(24'h123456, 24);
        check("long_high_valid", n_valid - v0, 1);
        check("long_high_word", int'(last_word), 24'h123456);
        check("long_high_no_more_err", n_err - e0, 1);

        v0 = n_valid;
        send_bits(24'hFFFFFF, 12);
        check("mid_reset_busy", int'(busy), 1);
        do_reset();
        check("mid_reset_no_valid", n_valid - v0, 0);
        send_bits(24'hFFFFFF, 24);
        check("after_reset_valid", n_valid - v0, 1);
        check("after_reset_word", int'(last_word), 24'hFFFFFF);

        check("latch_valid_overlap", n_overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
